data_mem_ctrl: RTL

Parametrised data-memory controller that replaces the fixed 16 KB word-only data memory wrapper. It generalises depth and width and adds byte-lane stores. Byte-lane stores are implemented as read-modify-write over a single-port synchronous RAM without native byte enables. It also adds an out-of-range address fault and a Ready handshake that stalls the CPU memory stage during merges. The block sits between the Kabeta memory stage and the inferred block RAM.

---
 rtl/data_mem_ctrl_pkg.sv | 29 ++
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/data_mem_ctrl_dmem_sram.sv | 51 +++++
 rtl/data_mem_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller.
// Holds the controller FSM state encoding and the byte-lane merge function
// used by the read-modify-write path.
package data_mem_ctrl_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_e;

  // The merge helper works on a fixed maximum width so one function serves
  // every DATA_WIDTH; callers zero-extend the inputs and truncate the result.
  localparam int MERGE_MAX_W = 256;

  // Lane i of the result is taken from new_w when be[i] is set, else from old_w.
  function automatic logic [MERGE_MAX_W-1:0] merge_lanes(
    input logic [MERGE_MAX_W-1:0]   old_w,
    input logic [MERGE_MAX_W-1:0]   new_w,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_W/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU memory-stage bus of the data-memory controller.
// master = CPU side (drives request), slave = controller side.
// Signals: addr, en_r, en_w, byte_en, data_w (request); data_r, ready, addr_fault (response).
interface data_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    en_r;
  logic                    en_w;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [DATA_WIDTH-1:0]   data_w;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    ready;
  logic                    addr_fault;

  modport master (
    output addr, en_r, en_w, byte_en, data_w,
    input  data_r, ready, addr_fault
  );

  modport slave (
    input  addr, en_r, en_w, byte_en, data_w,
    output data_r, ready, addr_fault
  );
endinterface

// File: rtl/data_mem_ctrl_dmem_sram.sv
// Purpose: single-port synchronous RAM, 2^DEPTH_LOG2 x DATA_WIDTH, no byte enables.
// Latency: registered read, data on o_rdata one cycle after i_en with i_we=0.
// Backpressure: none; accepts one access per cycle.
// Ports: i_clk, i_en (access), i_we (write), i_addr, i_wdata, o_rdata.
module dmem_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

`ifdef ALT_EP4CE
  altsyncram #(
    .operation_mode         ("SINGLE_PORT"),
    .width_a                (DATA_WIDTH),
    .widthad_a              (DEPTH_LOG2),
    .numwords_a             (2**DEPTH_LOG2),
    .outdata_reg_a          ("UNREGISTERED"),
    .read_during_write_mode_port_a ("DONT_CARE"),
    .intended_device_family ("Cyclone IV E"),
    .lpm_type               ("altsyncram")
  ) u_ram (
    .clock0    (i_clk),
    .clocken0  (i_en),
    .wren_a    (i_we),
    .address_a (i_addr),
    .data_a    (i_wdata),
    .q_a       (o_rdata)
  );
`else
  // Generic template; also the form Spartan-6 synthesis maps onto RAMB16 blocks
  // (XIL_XC6SLX builds use this branch).
  logic [DATA_WIDTH-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/data_mem_ctrl.sv
// Purpose: data-memory controller with range check and byte-lane stores via read-modify-write.
// Latency: reads 1 cycle; full writes 1 cycle; partial writes hold the bus for 2 cycles.
// Backpressure: ready drops for the single MERGE cycle of a partial write; CPU holds its request.
// Ports: i_clk, i_rst_n (async active-low), io_bus (slave side of data_mem_ctrl_if).
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  data_mem_ctrl_if.slave  io_bus
);

  localparam int NB = DATA_WIDTH / 8;

  state_e                r_state;
  state_e                w_state_nxt;

  logic [DEPTH_LOG2-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [NB-1:0]         r_hold_be;

  logic [DATA_WIDTH-1:0] r_data_hold;
  logic                  r_rd_pend;
  logic                  r_fault;

  logic                  w_oor;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] w_merge;
  logic                  w_rd_acc;
  logic                  w_oor_rd;
  logic                  w_fault;
  logic                  w_load;

  // With DEPTH_LOG2 == ADDR_WIDTH every address is in range.
  generate
    if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_range
      assign w_oor = |io_bus.addr[ADDR_WIDTH-1:DEPTH_LOG2];
    end else begin : g_no_range
      assign w_oor = 1'b0;
    end
  endgenerate

  // During MERGE the RAM output is the old word fetched in the accept cycle.
  assign w_merge = DATA_WIDTH'(merge_lanes(MERGE_MAX_W'(w_ram_q),
                                           MERGE_MAX_W'(r_hold_data),
                                           (MERGE_MAX_W/8)'(r_hold_be)));

  always_comb begin
    w_state_nxt = r_state;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = io_bus.addr[DEPTH_LOG2-1:0];
    w_ram_wdata = io_bus.data_w;
    w_rd_acc    = 1'b0;
    w_oor_rd    = 1'b0;
    w_fault     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // en_w wins over en_r: a combined request is a write only.
        if (io_bus.en_w) begin
          if (|io_bus.byte_en) begin
            if (w_oor) begin
              w_fault = 1'b1;
            end else if (&io_bus.byte_en) begin
              w_ram_en = 1'b1;
              w_ram_we = 1'b1;
            end else begin
              // Fetch the old word now; it is merged and written back in MERGE.
              w_ram_en    = 1'b1;
              w_load      = 1'b1;
              w_state_nxt = S_MERGE;
            end
          end
        end else if (io_bus.en_r) begin
          if (w_oor) begin
            w_fault  = 1'b1;
            w_oor_rd = 1'b1;
          end else begin
            w_ram_en = 1'b1;
            w_rd_acc = 1'b1;
          end
        end
      end
      S_MERGE: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = r_hold_addr;
        w_ram_wdata = w_merge;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_be   <= '0;
      r_data_hold <= '0;
      r_rd_pend   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fault   <= w_fault;
      r_rd_pend <= w_rd_acc;
      // Capture the RAM word of the previous read before the RAM output moves
      // on; a new out-of-range read overrides it with zero.
      if (w_oor_rd)       r_data_hold <= '0;
      else if (r_rd_pend) r_data_hold <= w_ram_q;
      if (w_load) begin
        r_hold_addr <= io_bus.addr[DEPTH_LOG2-1:0];
        r_hold_data <= io_bus.data_w;
        r_hold_be   <= io_bus.byte_en;
      end
    end
  end

  // The RAM read register doubles as Data_R in the cycle after a read, so
  // read latency stays at one cycle; afterwards the captured copy is shown,
  // which keeps RMW fetches and writes from disturbing Data_R.
  assign io_bus.data_r     = r_rd_pend ? w_ram_q : r_data_hold;
  assign io_bus.ready      = (r_state == S_IDLE);
  assign io_bus.addr_fault = r_fault;

  dmem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

endmodule
